// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package fetch_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] NOP          = 32'h0000_0000;
   localparam logic [31:0] PC_INC       = 32'd4;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/fetch_npc.sv
// PC register, next-PC mux (sequential / redirect target) and pending-redirect register.
module fetch_npc
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        capture,
   input  logic [31:0] cap_tgt,
   input  logic        load,
   output logic [31:0] pc,
   output logic        redir_active
);
   logic        pend_v;
   logic [31:0] pend_tgt;
   logic [31:0] redir_tgt;

   // A live redirect overrides an older pending one (last wins).
   assign redir_active = capture || pend_v;
   assign redir_tgt    = capture ? cap_tgt : pend_tgt;

   always_ff @(posedge clk) begin
      if (RESET) begin
         pc       <= RESET_PC;
         pend_v   <= 1'b0;
         pend_tgt <= NOP;
      end else if (load) begin
         pc       <= redir_active ? redir_tgt : pc + PC_INC;
         pend_v   <= 1'b0;
      end else if (capture) begin
         pend_v   <= 1'b1;
         pend_tgt <= cap_tgt;
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: request/ready fetch, stall hold buffer, D-stage redirects.
// Build option FETCH_DELAY_SLOT_EN selects delay-slot redirects; default squashes the fetch.
//
// state   | meaning
// S_FETCH | request outstanding, IM_Req=1
// S_HOLD  | instruction buffered while stalled, IM_Req=0
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        STALL_EN_N,
   output logic        IM_Req,
   output logic [31:0] IM_Addr,
   input  logic        IM_Ready,
   input  logic [31:0] IM_Rdata,
   input  logic        D_Redirect,
   input  logic [31:0] D_Target,
   output logic        F_Valid,
   output logic [31:0] F_Instr,
   output logic [31:0] F_InstrAddr
);
   fetch_state_e state, next_state;
   logic [31:0]  hold_instr, hold_addr;
   logic [31:0]  pc;
   logic         redir_active;
   logic         capture, fetch_ready;
   logic         squash, f_valid, handover, pc_load, hold_load;

   assign capture     = !RESET && D_Redirect && !STALL_EN_N;
   assign fetch_ready = (state == S_FETCH) && IM_Ready;

   fetch_npc #(.RESET_PC(RESET_PC)) u_npc (
      .clk          (clk),
      .RESET        (RESET),
      .capture      (capture),
      .cap_tgt      (D_Target),
      .load         (pc_load),
      .pc           (pc),
      .redir_active (redir_active)
   );

   always_comb begin
`ifdef FETCH_DELAY_SLOT_EN
      squash = 1'b0;
`else
      // Kill whatever is arriving or held once a redirect is known.
      squash = redir_active && (fetch_ready || (state == S_HOLD));
`endif
      f_valid    = !RESET && !squash && (fetch_ready || (state == S_HOLD));
      handover   = f_valid && !STALL_EN_N;
      pc_load    = !RESET && (handover || squash);
      hold_load  = !RESET && fetch_ready && STALL_EN_N && !squash;
      next_state = state;
      case (state)
         S_FETCH: if (hold_load) next_state = S_HOLD;
         S_HOLD:  if (pc_load)   next_state = S_FETCH;
         default: next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state      <= S_FETCH;
         hold_instr <= NOP;
         hold_addr  <= NOP;
      end else begin
         state <= next_state;
         if (hold_load) begin
            hold_instr <= IM_Rdata;
            hold_addr  <= pc;
         end
      end
   end

   always_comb begin
      IM_Req      = !RESET && (state == S_FETCH);
      IM_Addr     = pc;
      F_Valid     = f_valid;
      F_Instr     = NOP;
      F_InstrAddr = NOP;
      if (f_valid) begin
         F_Instr     = (state == S_HOLD) ? hold_instr : IM_Rdata;
         F_InstrAddr = (state == S_HOLD) ? hold_addr  : pc;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then random traffic against a reference model.
module tb_fetch_stage;
`ifdef FETCH_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        STALL_EN_N = 1'b0;
   logic        IM_Req;
   logic [31:0] IM_Addr;
   logic        IM_Ready = 1'b0;
   logic [31:0] IM_Rdata = 32'h0;
   logic        D_Redirect = 1'b0;
   logic [31:0] D_Target = 32'h0;
   logic        F_Valid;
   logic [31:0] F_Instr;
   logic [31:0] F_InstrAddr;

   int checks = 0;
   int failures = 0;

   fetch_stage dut (
      .clk         (clk),
      .RESET       (RESET),
      .STALL_EN_N  (STALL_EN_N),
      .IM_Req      (IM_Req),
      .IM_Addr     (IM_Addr),
      .IM_Ready    (IM_Ready),
      .IM_Rdata    (IM_Rdata),
      .D_Redirect  (D_Redirect),
      .D_Target    (D_Target),
      .F_Valid     (F_Valid),
      .F_Instr     (F_Instr),
      .F_InstrAddr (F_InstrAddr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, rdy, stl, rdr;
      logic [31:0] tgt, rdata;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] ins, ia;
   } vec_t;

   vec_t tv[29];

   function automatic vec_t mk(input logic rst, rdy, stl, rdr, input logic [31:0] tgt, rdata,
                               input logic req, input logic [31:0] addr,
                               input logic v, input logic [31:0] ins, ia);
      vec_t r;
      r.rst = rst; r.rdy = rdy; r.stl = stl; r.rdr = rdr; r.tgt = tgt; r.rdata = rdata;
      r.req = req; r.addr = addr; r.v = v; r.ins = ins; r.ia = ia;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_pend_t;
   bit          m_held;
   logic [31:0] m_hins, m_haddr;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      // rst rdy stl rdr tgt rdata | req addr v ins ia
      tv[0]  = mk(1,0,0,0, 0, 0,                         0, 32'h3000, 0, 0, 0);
      tv[1]  = mk(0,1,0,0, 0, 32'hA000_0001,             1, 32'h3000, 1, 32'hA000_0001, 32'h3000);
      tv[2]  = mk(0,1,0,0, 0, 32'hA000_0002,             1, 32'h3004, 1, 32'hA000_0002, 32'h3004);
      tv[3]  = mk(0,1,0,0, 0, 32'hA000_0003,             1, 32'h3008, 1, 32'hA000_0003, 32'h3008);
      tv[4]  = mk(0,0,0,0, 0, 32'h5555_5555,             1, 32'h300C, 0, 0, 0);
      tv[5]  = mk(0,0,0,0, 0, 32'h6666_6666,             1, 32'h300C, 0, 0, 0);
      tv[6]  = mk(0,1,0,0, 0, 32'hA000_0006,             1, 32'h300C, 1, 32'hA000_0006, 32'h300C);
      tv[7]  = mk(0,1,1,0, 0, 32'h2401_0005,             1, 32'h3010, 1, 32'h2401_0005, 32'h3010);
      tv[8]  = mk(0,1,1,0, 0, 32'hDEAD_BEEF,             0, 32'h3010, 1, 32'h2401_0005, 32'h3010);
      tv[9]  = mk(0,0,1,0, 0, 32'h7777_7777,             0, 32'h3010, 1, 32'h2401_0005, 32'h3010);
      tv[10] = mk(0,1,0,0, 0, 32'h1111_1111,             0, 32'h3010, 1, 32'h2401_0005, 32'h3010);
      tv[11] = mk(0,1,0,0, 0, 32'hA000_0011,             1, 32'h3014, 1, 32'hA000_0011, 32'h3014);
      tv[12] = mk(0,1,0,1, 32'h3100, 32'hA000_0012,      1, 32'h3018, DS,
                  DS ? 32'hA000_0012 : 32'h0, DS ? 32'h3018 : 32'h0);
      tv[13] = mk(0,0,0,0, 0, 32'h8888_8888,             1, 32'h3100, 0, 0, 0);
      tv[14] = mk(0,1,1,1, 32'h3200, 32'hA000_0014,      1, 32'h3100, 1, 32'hA000_0014, 32'h3100);
      tv[15] = mk(0,0,1,1, 32'h3200, 32'h9999_9999,      0, 32'h3100, 1, 32'hA000_0014, 32'h3100);
      tv[16] = mk(0,0,0,0, 0, 32'h9999_9999,             0, 32'h3100, 1, 32'hA000_0014, 32'h3100);
      tv[17] = mk(0,0,0,1, 32'h3020, 32'h1234_5678,      1, 32'h3104, 0, 0, 0);
      tv[18] = mk(0,1,0,0, 0, 32'hA000_0018,             1, 32'h3104, DS,
                  DS ? 32'hA000_0018 : 32'h0, DS ? 32'h3104 : 32'h0);
      tv[19] = mk(1,1,0,0, 0, 32'hA000_0019,             0, 32'h3020, 0, 0, 0);
      tv[20] = mk(0,0,0,0, 0, 32'hA000_0020,             1, 32'h3000, 0, 0, 0);
      tv[21] = mk(0,0,0,0, 0, 32'hA000_0021,             1, 32'h3000, 0, 0, 0);
      tv[22] = mk(0,1,0,0, 0, 32'hA000_0022,             1, 32'h3000, 1, 32'hA000_0022, 32'h3000);
      tv[23] = mk(0,1,1,0, 0, 32'hA000_0023,             1, 32'h3004, 1, 32'hA000_0023, 32'h3004);
      tv[24] = mk(0,0,0,1, 32'h3300, 32'h4444_4444,      0, 32'h3004, DS,
                  DS ? 32'hA000_0023 : 32'h0, DS ? 32'h3004 : 32'h0);
      tv[25] = mk(0,0,0,0, 0, 32'h0,                     1, 32'h3300, 0, 0, 0);
      tv[26] = mk(0,1,0,1, 32'hFFFF_FFFC, 32'hA000_0026, 1, 32'h3300, DS,
                  DS ? 32'hA000_0026 : 32'h0, DS ? 32'h3300 : 32'h0);
      tv[27] = mk(0,1,0,0, 0, 32'hA000_0027,             1, 32'hFFFF_FFFC, 1, 32'hA000_0027, 32'hFFFF_FFFC);
      tv[28] = mk(0,0,0,0, 0, 32'h0,                     1, 32'h0000_0000, 0, 0, 0);

      RESET = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 29; i++) begin
         RESET = tv[i].rst; IM_Ready = tv[i].rdy; STALL_EN_N = tv[i].stl;
         D_Redirect = tv[i].rdr; D_Target = tv[i].tgt; IM_Rdata = tv[i].rdata;
         #2;
         check($sformatf("vec%0d IM_Req", i), {31'b0, IM_Req}, {31'b0, tv[i].req});
         check($sformatf("vec%0d IM_Addr", i), IM_Addr, tv[i].addr);
         check($sformatf("vec%0d F_Valid", i), {31'b0, F_Valid}, {31'b0, tv[i].v});
         check($sformatf("vec%0d F_Instr", i), F_Instr, tv[i].ins);
         check($sformatf("vec%0d F_InstrAddr", i), F_InstrAddr, tv[i].ia);
         @(posedge clk); #1;
      end

      // Random traffic; the first cycle is a reset so the model starts in a known state.
      m_pc = 32'h0; m_pend = 0; m_pend_t = 32'h0; m_held = 0; m_hins = 32'h0; m_haddr = 32'h0;
      for (int c = 0; c < 2000; c++) begin
         bit live, avail, kill, valid, advance;
         logic [31:0] e_ins, e_ia;
         RESET      = (c == 0) || ($urandom_range(0, 63) == 0);
         IM_Ready   = ($urandom_range(0, 3) != 0);
         STALL_EN_N = ($urandom_range(0, 2) == 0);
         D_Redirect = ($urandom_range(0, 7) == 0);
         D_Target   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         IM_Rdata   = $urandom;
         #2;
         if (RESET) begin
            check("rnd IM_Req", {31'b0, IM_Req}, 32'h0);
            check("rnd F_Valid", {31'b0, F_Valid}, 32'h0);
            check("rnd F_Instr", F_Instr, 32'h0);
            check("rnd F_InstrAddr", F_InstrAddr, 32'h0);
            m_pc = 32'h3000; m_pend = 0; m_held = 0;
         end else begin
            live  = D_Redirect && !STALL_EN_N;
            avail = m_held || IM_Ready;
            kill  = DS ? 1'b0 : (m_held ? live : (IM_Ready && (live || m_pend)));
            valid = avail && !kill;
            w     = m_held ? m_hins : IM_Rdata;
            e_ins = valid ? w : 32'h0;
            e_ia  = valid ? (m_held ? m_haddr : m_pc) : 32'h0;
            check("rnd IM_Req", {31'b0, IM_Req}, {31'b0, !m_held});
            check("rnd IM_Addr", IM_Addr, m_pc);
            check("rnd F_Valid", {31'b0, F_Valid}, {31'b0, valid});
            check("rnd F_Instr", F_Instr, e_ins);
            check("rnd F_InstrAddr", F_InstrAddr, e_ia);
            advance = (valid && !STALL_EN_N) || kill;
            if (advance) begin
               m_pc   = live ? D_Target : (m_pend ? m_pend_t : m_pc + 32'd4);
               m_pend = 0;
               m_held = 0;
            end else begin
               if (live) begin
                  m_pend = 1; m_pend_t = D_Target;
               end
               if (!m_held && IM_Ready && STALL_EN_N) begin
                  m_held = 1; m_hins = IM_Rdata; m_haddr = m_pc;
               end
            end
         end
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
